// File: rtl/mips_pkg.sv
// Shared pipeline-control types and constants for the MIPS hazard logic.
package mips_pkg;

   localparam int unsigned REG_W         = 5;
   localparam int unsigned MD_CNT_W      = 8;
   localparam int unsigned MD_CYCLES_DEF = 32;
   localparam int unsigned CNT_W_DEF     = 16;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: ID/EX observations in,
// pipeline-register enables, bubbles and performance counters out.
interface hazard_ctrl_if
   import mips_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) ();

   logic [REG_W-1:0] ID_RS;
   logic [REG_W-1:0] ID_RT;
   logic             ID_UsesRT;
   logic             EX_MemRead;
   logic [REG_W-1:0] EX_RT;
   logic             EX_Branch_taken;
   logic             EX_MD_start;

   logic             PC_Write;
   logic             IFID_Write;
   logic             IFID_Flush;
   logic             IDEX_Write;
   logic             IDEX_Bubble;
   logic             EXMEM_Bubble;
   logic             MD_busy;
   logic             MD_done;
   logic [CNT_W-1:0] Stall_cnt;
   logic [CNT_W-1:0] Flush_cnt;

   modport master (
      output ID_RS, ID_RT, ID_UsesRT, EX_MemRead, EX_RT, EX_Branch_taken, EX_MD_start,
      input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
             MD_busy, MD_done, Stall_cnt, Flush_cnt
   );

   modport slave (
      input  ID_RS, ID_RT, ID_UsesRT, EX_MemRead, EX_RT, EX_Branch_taken, EX_MD_start,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
             MD_busy, MD_done, Stall_cnt, Flush_cnt
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// multi-cycle mult/div EX occupancy, plus stall/flush event counters.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MD_CYCLES = MD_CYCLES_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input logic          clk_i,
   input logic          rst_i,
   hazard_ctrl_if.slave bus
);

   // Start cycle plus the reload value's countdown make MD_CYCLES-1 stall cycles.
   localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_CYCLES - 2);

   state_t              state;
   state_t              state_nxt;
   logic [MD_CNT_W-1:0] md_cnt;
   logic [MD_CNT_W-1:0] md_cnt_nxt;
   logic                load_use;

   logic pc_write;
   logic ifid_write;
   logic ifid_flush;
   logic idex_write;
   logic idex_bubble;
   logic exmem_bubble;
   logic md_busy;
   logic md_done;

   assign load_use = bus.EX_MemRead && (bus.EX_RT != '0) &&
                     ((bus.EX_RT == bus.ID_RS) || (bus.ID_UsesRT && (bus.EX_RT == bus.ID_RT)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      md_cnt_nxt   = md_cnt;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;
      if (!rst_i) begin
         case (state)
            RUN: begin
               if (bus.EX_Branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (bus.EX_MD_start) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_bubble = 1'b1;
                  md_busy      = 1'b1;
                  state_nxt    = MD_BUSY;
                  md_cnt_nxt   = MD_RELOAD;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_cnt != '0) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_bubble = 1'b1;
                  md_busy      = 1'b1;
                  md_cnt_nxt   = md_cnt - MD_CNT_W'(1);
               end else begin
                  // Result cycle: front end is free again, so a pending load-use still stalls.
                  md_done   = 1'b1;
                  state_nxt = RUN;
                  if (load_use) begin
                     pc_write    = 1'b0;
                     ifid_write  = 1'b0;
                     idex_bubble = 1'b1;
                  end
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   assign bus.PC_Write     = pc_write;
   assign bus.IFID_Write   = ifid_write;
   assign bus.IFID_Flush   = ifid_flush;
   assign bus.IDEX_Write   = idex_write;
   assign bus.IDEX_Bubble  = idex_bubble;
   assign bus.EXMEM_Bubble = exmem_bubble;
   assign bus.MD_busy      = md_busy;
   assign bus.MD_done      = md_done;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (~pc_write),
      .count (bus.Stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .inc   (ifid_flush),
      .count (bus.Flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations driven in lockstep and checked
// against a cycle-age reference model of the hazard rules.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_usesrt = 1'b0;
   logic       ex_memread = 1'b0;
   logic [4:0] ex_rt = '0;
   logic       ex_branch = 1'b0;
   logic       ex_md_start = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // Instance 0: MD_CYCLES=4, CNT_W=4; 1: MD_CYCLES=2; 2: MD_CYCLES=32.
   int mcyc[3]   = '{4, 2, 32};
   int cmax[3]   = '{15, 65535, 65535};
   int md_age[3] = '{-1, -1, -1};
   int stall_m[3] = '{0, 0, 0};
   int flush_m[3] = '{0, 0, 0};

   logic [7:0]  obs_flags[3];
   logic [15:0] obs_stall[3];
   logic [15:0] obs_flush[3];

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(4))  if_a ();
   hazard_ctrl_if #(.CNT_W(16)) if_b ();
   hazard_ctrl_if #(.CNT_W(16)) if_c ();

   hazard_ctrl #(.MD_CYCLES(4),  .CNT_W(4))  dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
   hazard_ctrl #(.MD_CYCLES(2),  .CNT_W(16)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));
   hazard_ctrl #(.MD_CYCLES(32), .CNT_W(16)) dut_c (.clk_i(clk), .rst_i(rst), .bus(if_c.slave));

   assign if_a.ID_RS = id_rs;   assign if_b.ID_RS = id_rs;   assign if_c.ID_RS = id_rs;
   assign if_a.ID_RT = id_rt;   assign if_b.ID_RT = id_rt;   assign if_c.ID_RT = id_rt;
   assign if_a.ID_UsesRT = id_usesrt;
   assign if_b.ID_UsesRT = id_usesrt;
   assign if_c.ID_UsesRT = id_usesrt;
   assign if_a.EX_MemRead = ex_memread;
   assign if_b.EX_MemRead = ex_memread;
   assign if_c.EX_MemRead = ex_memread;
   assign if_a.EX_RT = ex_rt;   assign if_b.EX_RT = ex_rt;   assign if_c.EX_RT = ex_rt;
   assign if_a.EX_Branch_taken = ex_branch;
   assign if_b.EX_Branch_taken = ex_branch;
   assign if_c.EX_Branch_taken = ex_branch;
   assign if_a.EX_MD_start = ex_md_start;
   assign if_b.EX_MD_start = ex_md_start;
   assign if_c.EX_MD_start = ex_md_start;

   assign obs_flags[0] = {if_a.PC_Write, if_a.IFID_Write, if_a.IFID_Flush, if_a.IDEX_Write,
                          if_a.IDEX_Bubble, if_a.EXMEM_Bubble, if_a.MD_busy, if_a.MD_done};
   assign obs_flags[1] = {if_b.PC_Write, if_b.IFID_Write, if_b.IFID_Flush, if_b.IDEX_Write,
                          if_b.IDEX_Bubble, if_b.EXMEM_Bubble, if_b.MD_busy, if_b.MD_done};
   assign obs_flags[2] = {if_c.PC_Write, if_c.IFID_Write, if_c.IFID_Flush, if_c.IDEX_Write,
                          if_c.IDEX_Bubble, if_c.EXMEM_Bubble, if_c.MD_busy, if_c.MD_done};
   assign obs_stall[0] = 16'(if_a.Stall_cnt);
   assign obs_stall[1] = if_b.Stall_cnt;
   assign obs_stall[2] = if_c.Stall_cnt;
   assign obs_flush[0] = 16'(if_a.Flush_cnt);
   assign obs_flush[1] = if_b.Flush_cnt;
   assign obs_flush[2] = if_c.Flush_cnt;

   // md_age: cycles since the mult/div start cycle (0), or -1 when none is in flight.
   task automatic check_inst(input int k);
      logic [7:0] e;
      logic pc, ifw, fl, idw, bub, exb, bsy, dn;
      bit lu;
      int m;
      int nxt;
      m   = mcyc[k];
      nxt = -1;
      lu  = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (id_usesrt && (ex_rt == id_rt)));
      pc = 1; ifw = 1; fl = 0; idw = 1; bub = 0; exb = 0; bsy = 0; dn = 0;
      if (!rst) begin
         if (md_age[k] >= 1 && md_age[k] <= m - 2) begin
            pc = 0; ifw = 0; idw = 0; exb = 1; bsy = 1;
            nxt = md_age[k] + 1;
         end else if (md_age[k] == m - 1) begin
            dn = 1;
            if (lu) begin pc = 0; ifw = 0; bub = 1; end
         end else if (ex_branch) begin
            fl = 1; bub = 1;
         end else if (ex_md_start) begin
            pc = 0; ifw = 0; idw = 0; exb = 1; bsy = 1;
            nxt = 1;
         end else if (lu) begin
            pc = 0; ifw = 0; bub = 1;
         end
      end
      e = {pc, ifw, fl, idw, bub, exb, bsy, dn};

      n_cmp++;
      assert (obs_flags[k] === e) else begin
         n_err++;
         $error("FAIL flags[%0d] t=%0t observed=%b expected=%b", k, $time, obs_flags[k], e);
      end
      n_cmp++;
      assert (obs_stall[k] === 16'(stall_m[k])) else begin
         n_err++;
         $error("FAIL stall_cnt[%0d] t=%0t observed=%0d expected=%0d", k, $time, obs_stall[k], stall_m[k]);
      end
      n_cmp++;
      assert (obs_flush[k] === 16'(flush_m[k])) else begin
         n_err++;
         $error("FAIL flush_cnt[%0d] t=%0t observed=%0d expected=%0d", k, $time, obs_flush[k], flush_m[k]);
      end

      md_age[k] = nxt;
      if (rst) begin
         stall_m[k] = 0;
         flush_m[k] = 0;
      end else begin
         if (!pc && stall_m[k] < cmax[k]) stall_m[k]++;
         if (fl && flush_m[k] < cmax[k]) flush_m[k]++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_inst(k);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; id_usesrt = 1'b0;
      ex_memread = 1'b0; ex_rt = '0; ex_branch = 1'b0; ex_md_start = 1'b0;
   endtask

   initial begin
      idle_inputs();
      @(posedge clk);
      #1;
      step();
      step();
      rst = 1'b0;
      step();

      // Load-use via rs, then counter visible next cycle
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      step();
      idle_inputs();
      step();

      // r0 never hazards; rt ignored unless used as a source
      ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      step();
      ex_rt = 5'd9; id_rt = 5'd9; id_usesrt = 1'b0; id_rs = 5'd1;
      step();
      id_usesrt = 1'b1;
      step();
      idle_inputs();

      // Branch overrides load-use
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch = 1'b1;
      step();
      idle_inputs();
      step();

      // Mult/div pulse, run all three instances to completion
      ex_md_start = 1'b1;
      step();
      idle_inputs();
      repeat (35) step();

      // Branch with MD start: flush only
      ex_md_start = 1'b1; ex_branch = 1'b1;
      step();
      idle_inputs();
      step();

      // Reset in the second cycle of a mult/div
      ex_md_start = 1'b1;
      step();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      step();

      // Long load-use run saturates the 4-bit counter
      ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
      repeat (20) step();
      idle_inputs();
      step();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit any_done;
         any_done = 1'b0;
         for (int k = 0; k < 3; k++) if (md_age[k] == mcyc[k] - 1) any_done = 1'b1;
         rst         = ($urandom_range(0, 63) == 0);
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         id_usesrt   = 1'($urandom_range(0, 1));
         ex_memread  = 1'($urandom_range(0, 1));
         ex_rt       = 5'($urandom_range(0, 3));
         ex_branch   = any_done ? 1'b0 : ($urandom_range(0, 7) == 0);
         ex_md_start = any_done ? 1'b0 : ($urandom_range(0, 15) == 0);
         step();
      end
      rst = 1'b0;
      idle_inputs();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 32: total EX occupancy of a mult/div instruction in cycles; legal range 2..256.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 ID_RS  in  5  rs field of the instruction in ID.
REQ-006 ID_RT  in  5  rt field of the instruction in ID.
REQ-007 ID_UsesRT  in  1  ID instruction reads rt as a source.
REQ-008 EX_MemRead  in  1  EX instruction is a load.
REQ-009 EX_RT  in  5  destination register of the load in EX.
REQ-010 EX_Branch_taken  in  1  branch/jump in EX resolved taken this cycle.
REQ-011 EX_MD_start  in  1  mult/div instruction entered EX this cycle.
REQ-012 PC_Write  out  1  PC may update.
REQ-013 IFID_Write  out  1  IF/ID register may load.
REQ-014 IFID_Flush  out  1  IF/ID register loads a NOP.
REQ-015 IDEX_Write  out  1  ID/EX register may load.
REQ-016 IDEX_Bubble  out  1  ID/EX register loads a NOP with all control bits 0.
REQ-017 EXMEM_Bubble  out  1  EX/MEM register loads a NOP.
REQ-018 MD_busy  out  1  mult/div occupying EX.
REQ-019 MD_done  out  1  one-cycle pulse: mult/div result valid in EX.
REQ-020 Stall_cnt  out  CNT_W  count of front-end stall cycles.
REQ-021 Flush_cnt  out  CNT_W  count of branch flushes.

Function
REQ-022 FSM states RUN and MD_BUSY; 8-bit down-counter md_cnt.
REQ-023 Default outputs (no event): PC_Write=1, IFID_Write=1, IDEX_Write=1, all flush/bubble/MD outputs 0.
REQ-024 Load-use hazard (RUN): EX_MemRead && EX_RT!=0 && (EX_RT==ID_RS || (ID_UsesRT && EX_RT==ID_RT)); same cycle: PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
REQ-025 Branch flush (RUN): EX_Branch_taken -> same cycle IFID_Flush=1, IDEX_Bubble=1, PC_Write=1.
REQ-026 Branch flush overrides a simultaneous load-use hazard.
REQ-027 EX_MD_start in RUN without EX_Branch_taken: same cycle PC_Write=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1, MD_busy=1; next state MD_BUSY, md_cnt <= MD_CYCLES-2.
REQ-028 EX_MD_start together with EX_Branch_taken: flush only; EX_MD_start ignored.
REQ-029 MD_BUSY, md_cnt!=0: stall outputs as REQ-027, md_cnt decrements; EX_Branch_taken, EX_MD_start ignored.
REQ-030 MD_BUSY, md_cnt==0: no MD stall, MD_done=1, MD_busy=0, next state RUN; load-use detection active this cycle.
REQ-031 Total stalled cycles per mult/div = MD_CYCLES-1; MD_done in the MD_CYCLES-th cycle after start.
REQ-032 Stall_cnt increments on every cycle with PC_Write=0; Flush_cnt increments on every cycle with IFID_Flush=1.
REQ-033 Both counters saturate at 2^CNT_W-1; no wrap.
REQ-034 All outputs combinational from state, md_cnt and current inputs; zero added latency.

Reset
REQ-035 rst_i high at an edge: state <= RUN, md_cnt <= 0, Stall_cnt <= 0, Flush_cnt <= 0, including mid-MD_BUSY.
REQ-036 While rst_i is high, outputs equal the REQ-023 defaults; counters do not increment.

Structure
REQ-037 Shared package mips_pkg holds the FSM state enum and the MD_CYCLES default constant.
REQ-038 One sub-module sat_counter (CNT_W wide, inc input, sync reset), instantiated twice for Stall_cnt and Flush_cnt.

Verification
REQ-039 EX_MemRead=1, EX_RT=8, ID_RS=8 for one cycle -> that cycle PC_Write=0, IFID_Write=0, IDEX_Bubble=1; Stall_cnt=1 next cycle.
REQ-040 EX_MemRead=1, EX_RT=0, ID_RS=0 -> no stall; EX_RT=9, ID_RT=9, ID_UsesRT=0 -> no stall.
REQ-041 Load-use hazard plus EX_Branch_taken same cycle -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; Flush_cnt +1, Stall_cnt unchanged.
REQ-042 MD_CYCLES=4, EX_MD_start pulse -> 3 cycles EXMEM_Bubble=1 and PC_Write=0, MD_done=1 in 4th cycle, RUN afterwards; MD_CYCLES=2 -> exactly 1 stall cycle.
REQ-043 rst_i asserted in 2nd cycle of a 32-cycle mult/div -> next cycle RUN, defaults, counters 0.
REQ-044 CNT_W=4, 20 consecutive load-use stall cycles -> Stall_cnt holds at 15.
